// File: rtl/sram_mem_multiport.sv
// Multi-requester word-addressed SRAM bank with round-robin arbitration, relocated
// address decode, fixed-latency fully pipelined responses and an error response for
// accesses outside [BaseAddr, BaseAddr + Depth*Width/8).
// Optional feature: define SRAM_STALL_INJECT_EN to withhold grants pseudo-randomly
// (16-bit Fibonacci LFSR, taps 16,14,13,11, seeded with StallSeed).
module sram_mem_multiport #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned Width       = 32,
    parameter int unsigned Depth       = 1 << 20,
    parameter logic [31:0] BaseAddr    = 32'h8000_0000,
    parameter int unsigned ReadLatency = 1,
    parameter logic [15:0] StallSeed   = 16'hACE1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumChannels-1:0]          req_i,
    output logic [NumChannels-1:0]          gnt_o,
    input  logic [NumChannels*32-1:0]       addr_i,
    input  logic [NumChannels-1:0]          we_i,
    input  logic [NumChannels*Width-1:0]    wdata_i,
    input  logic [NumChannels*Width/8-1:0]  strb_i,
    output logic [NumChannels-1:0]          rvalid_o,
    output logic [NumChannels*Width-1:0]    rdata_o,
    output logic [NumChannels-1:0]          err_o
);

    localparam int unsigned NumBytes  = Width / 8;
    localparam int unsigned ByteShift = $clog2(NumBytes);
    localparam int unsigned IdxW      = $clog2(Depth);
    localparam int unsigned PtrW      = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    logic [PtrW-1:0]     ptr_q, ptr_d;
    logic                stall;
    logic                gnt_any;
    logic [PtrW-1:0]     gnt_idx;

    logic [31:0]         sel_addr;
    logic                sel_we;
    logic [Width-1:0]    sel_wdata;
    logic [NumBytes-1:0] sel_strb;
    logic [31:0]         off;
    logic [31:0]         word;
    logic                in_range;
    logic [IdxW-1:0]     mem_idx;
    logic [Width-1:0]    rd_word;
    logic                rd_err;

    logic [Width-1:0]    mem [Depth];

    // Response pipeline: stage 0 is loaded at the grant edge, last stage drives outputs.
    logic [NumChannels-1:0] pv_q [ReadLatency];
    logic [Width-1:0]       pd_q [ReadLatency];
    logic                   pe_q [ReadLatency];

`ifdef SRAM_STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = lfsr_q[0];

    // Stall LFSR advances every cycle regardless of traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= StallSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [15:0] unused_seed;

    assign unused_seed = StallSeed;
    assign stall       = 1'b0;
`endif

    // Round-robin arbiter: first requesting channel at or after the pointer wins.
    always_comb begin : arb
        int unsigned c;
        c       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            c = (32'(ptr_q) + i) % NumChannels;
            if (!gnt_any && !stall && req_i[c]) begin
                gnt_any = 1'b1;
                gnt_idx = PtrW'(c);
            end
        end
        gnt_o = gnt_any ? (NumChannels'(1) << gnt_idx) : '0;
        ptr_d = gnt_any ? PtrW'((32'(gnt_idx) + 1) % NumChannels) : ptr_q;
    end

    // Steer the winner's request fields and decode its address.
    always_comb begin
        sel_addr  = addr_i[gnt_idx*32 +: 32];
        sel_we    = we_i[gnt_idx];
        sel_wdata = wdata_i[gnt_idx*Width +: Width];
        sel_strb  = strb_i[gnt_idx*NumBytes +: NumBytes];
        off       = sel_addr - BaseAddr;
        word      = off >> ByteShift;
        in_range  = (sel_addr >= BaseAddr) && (word < Depth);
        mem_idx   = word[IdxW-1:0];
        rd_word   = (gnt_any && !sel_we && in_range) ? mem[mem_idx] : '0;
        rd_err    = gnt_any && !in_range;
    end

    // Byte-masked write at the grant edge; array deliberately has no reset.
    always_ff @(posedge clk_i) begin
        if (gnt_any && sel_we && in_range) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (sel_strb[b]) begin
                    mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Arbitration pointer and response pipeline; reset discards in-flight responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < ReadLatency; i++) begin
                pv_q[i] <= '0;
                pd_q[i] <= '0;
                pe_q[i] <= 1'b0;
            end
        end else begin
            ptr_q   <= ptr_d;
            pv_q[0] <= gnt_o;
            pd_q[0] <= rd_word;
            pe_q[0] <= rd_err;
            for (int unsigned i = 1; i < ReadLatency; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    // Fan the last pipeline stage out to the owning channel; others read as zero.
    always_comb begin
        rvalid_o = pv_q[ReadLatency-1];
        rdata_o  = '0;
        err_o    = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (pv_q[ReadLatency-1][c]) begin
                rdata_o[c*Width +: Width] = pd_q[ReadLatency-1];
                err_o[c]                  = pe_q[ReadLatency-1];
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_multiport.sv
// Directed bench for sram_mem_multiport: vector table on a 3-channel, latency-2 bank,
// plus sequences for reset, round-robin, read-after-write, latency sweep and stall injection.
module tb_sram_mem_multiport;

    localparam int MainLat = 2;
    localparam logic [31:0] RrData [3] = '{32'hAABBCCDD, 32'hDEAD55EF, 32'h12345678};

    typedef struct {
        int          ch;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, we, gnt, rvalid, err;
    logic [95:0] addr, wdata, rdata;
    logic [11:0] strb;

    logic [1:0]  sw_req, sw_we;
    logic [63:0] sw_addr, sw_wdata;
    logic [7:0]  sw_strb;
    logic [1:0]  sw_gnt [4];
    logic [1:0]  sw_rvalid [4];
    logic [1:0]  sw_err [4];
    logic [63:0] sw_rdata [4];

    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    sram_mem_multiport #(
        .NumChannels (3),
        .Width       (32),
        .Depth       (1024),
        .BaseAddr    (32'h8000_0000),
        .ReadLatency (MainLat),
        .StallSeed   (16'hACE1)
    ) u_dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .gnt_o    (gnt),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .strb_i   (strb),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        sram_mem_multiport #(
            .NumChannels (2),
            .Width       (32),
            .Depth       (64),
            .BaseAddr    (32'h8000_0000),
            .ReadLatency (g + 1),
            .StallSeed   (16'hACE1)
        ) u_sw (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .req_i    (sw_req),
            .gnt_o    (sw_gnt[g]),
            .addr_i   (sw_addr),
            .we_i     (sw_we),
            .wdata_i  (sw_wdata),
            .strb_i   (sw_strb),
            .rvalid_o (sw_rvalid[g]),
            .rdata_o  (sw_rdata[g]),
            .err_o    (sw_err[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int          waited;
        logic [2:0]  oh;
        logic [95:0] ev;
        waited = 0;
        oh     = 3'(1 << v.ch);
        ev     = '0;
        ev[v.ch*32 +: 32] = v.exp_rdata;
        @(negedge clk);
        req                  = oh;
        we[v.ch]             = v.we;
        addr[v.ch*32 +: 32]  = v.addr;
        wdata[v.ch*32 +: 32] = v.wdata;
        strb[v.ch*4 +: 4]    = v.strb;
        #1;
        while (gnt !== oh && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check($sformatf("v%0d gnt", idx), gnt, oh);
        for (int k = 1; k <= MainLat; k++) begin
            @(negedge clk);
            if (k == 1) req = '0;
            #1;
            if (k < MainLat) begin
                check($sformatf("v%0d early rvalid", idx), rvalid, 3'b000);
            end else begin
                check($sformatf("v%0d rvalid", idx), rvalid, oh);
                check($sformatf("v%0d err", idx), err, v.exp_err ? oh : 3'b000);
                check($sformatf("v%0d rdata", idx), rdata, ev);
            end
        end
    endtask

`ifdef SRAM_STALL_INJECT_EN
    task automatic stall_test();
        logic [15:0] m;
        int          exp_g, got_g, got_rv;
        exp_g  = 0;
        got_g  = 0;
        got_rv = 0;
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        m          = 16'hACE1;
        req        = 3'b001;
        we[0]      = 1'b0;
        addr[31:0] = 32'h8000_0000;
        for (int i = 0; i < 40; i++) begin
            #1;
            check($sformatf("stall gnt %0d", i), gnt, m[0] ? 3'b000 : 3'b001);
            if (!m[0]) exp_g++;
            if (gnt[0]) got_g++;
            if (rvalid[0]) got_rv++;
            @(negedge clk);
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end
        req = '0;
        for (int i = 0; i < MainLat + 1; i++) begin
            #1;
            if (rvalid[0]) got_rv++;
            @(negedge clk);
        end
        check("stall grant count", 128'(got_g), 128'(exp_g));
        check("stall rvalid count", 128'(got_rv), 128'(exp_g));
    endtask
`else
    task automatic reset_test();
        @(negedge clk);
        req        = 3'b001;
        we[0]      = 1'b0;
        addr[31:0] = 32'h8000_0000;
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        #1;
        check("midrst gnt", gnt, 3'b000);
        check("midrst rvalid", rvalid, 3'b000);
        check("midrst rdata", rdata, 96'h0);
        check("midrst err", err, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("postrst rvalid %0d", i), rvalid, 3'b000);
            @(negedge clk);
        end
    endtask

    task automatic rr_test();
        int          t;
        int          c;
        logic [2:0]  ev;
        logic [95:0] ed;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req  = 3'b111;
                we   = 3'b000;
                addr = {32'h8000_0FFC, 32'h8000_0010, 32'h8000_0000};
            end
            if (i == 4) req = '0;
            #1;
            check($sformatf("rr gnt %0d", i), gnt, (i < 4) ? 3'(1 << (i % 3)) : 3'b000);
            t  = i - MainLat;
            ev = '0;
            ed = '0;
            if (t >= 0 && t < 4) begin
                c  = t % 3;
                ev = 3'(1 << c);
                ed[c*32 +: 32] = RrData[c];
            end
            check($sformatf("rr rvalid %0d", i), rvalid, ev);
            check($sformatf("rr rdata %0d", i), rdata, ed);
        end
    endtask

    task automatic raw_test();
        @(negedge clk);
        req         = 3'b001;
        we[0]       = 1'b1;
        addr[31:0]  = 32'h8000_0020;
        wdata[31:0] = 32'hCAFEF00D;
        strb[3:0]   = 4'hF;
        #1;
        check("raw wr gnt", gnt, 3'b001);
        @(negedge clk);
        we[0] = 1'b0;
        #1;
        check("raw rd gnt", gnt, 3'b001);
        @(negedge clk);
        req = '0;
        #1;
        check("raw wr rvalid", rvalid, 3'b001);
        check("raw wr rdata", rdata, 96'h0);
        @(negedge clk);
        #1;
        check("raw rd rvalid", rvalid, 3'b001);
        check("raw rd rdata", rdata, {64'h0, 32'hCAFEF00D});
        @(negedge clk);
        #1;
        check("raw idle rvalid", rvalid, 3'b000);
    endtask

    task automatic sweep_test();
        int          t;
        logic [1:0]  exp_v;
        logic [63:0] exp_d;
        for (int j = 0; j < 13; j++) begin
            @(negedge clk);
            if (j < 8) begin
                sw_req            = 2'b10;
                sw_we[1]          = (j < 4);
                sw_addr[63:32]    = 32'h8000_0000 + 32'(4 * (j % 4));
                sw_wdata[63:32]   = 32'h0F0F_0000 | 32'(j % 4);
                sw_strb[7:4]      = 4'hF;
            end else begin
                sw_req = '0;
            end
            #1;
            for (int g = 0; g < 4; g++) begin
                t     = j - (g + 1);
                exp_v = (t >= 0 && t < 8) ? 2'b10 : 2'b00;
                exp_d = (t >= 4 && t < 8) ? {32'h0F0F_0000 | 32'(t - 4), 32'h0} : 64'h0;
                check($sformatf("sweep L%0d c%0d gnt", g + 1, j), sw_gnt[g],
                      (j < 8) ? 2'b10 : 2'b00);
                check($sformatf("sweep L%0d c%0d rvalid", g + 1, j), sw_rvalid[g], exp_v);
                check($sformatf("sweep L%0d c%0d rdata", g + 1, j), sw_rdata[g], exp_d);
                check($sformatf("sweep L%0d c%0d err", g + 1, j), sw_err[g], 2'b00);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        we       = '0;
        addr     = '0;
        wdata    = '0;
        strb     = '0;
        sw_req   = '0;
        sw_we    = '0;
        sw_addr  = '0;
        sw_wdata = '0;
        sw_strb  = '0;

        vecs[0]  = '{0, 1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{0, 1'b0, 32'h8000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{0, 1'b1, 32'h8000_0010, 32'h00005500, 4'h2, 32'h0,        1'b0};
        vecs[3]  = '{0, 1'b0, 32'h8000_0010, 32'h0,        4'h0, 32'hDEAD55EF, 1'b0};
        vecs[4]  = '{1, 1'b0, 32'h8000_0013, 32'h0,        4'h0, 32'hDEAD55EF, 1'b0};
        vecs[5]  = '{0, 1'b1, 32'h8000_0000, 32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
        vecs[6]  = '{2, 1'b1, 32'h8000_0FFC, 32'h12345678, 4'hF, 32'h0,        1'b0};
        vecs[7]  = '{2, 1'b1, 32'h8000_0000, 32'h11111111, 4'h0, 32'h0,        1'b0};
        vecs[8]  = '{1, 1'b0, 32'h7FFF_FFFC, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[9]  = '{1, 1'b0, 32'h8000_1000, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[10] = '{0, 1'b1, 32'h8000_1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{2, 1'b1, 32'h7FFF_FFFC, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[12] = '{0, 1'b0, 32'h8000_0000, 32'h0,        4'h0, 32'hAABBCCDD, 1'b0};
        vecs[13] = '{1, 1'b0, 32'h8000_0FFC, 32'h0,        4'h0, 32'h12345678, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        check("reset gnt", gnt, 3'b000);
        check("reset rvalid", rvalid, 3'b000);
        check("reset rdata", rdata, 96'h0);
        check("reset err", err, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_txn(i, vecs[i]);
        end

`ifdef SRAM_STALL_INJECT_EN
        stall_test();
`else
        reset_test();
        rr_test();
        raw_test();
        sweep_test();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
